// File: rtl/axis_decimation_controller.sv
// axis_decimation_controller
//
// Decimates the dual-lane 14-bit ADC stream by averaging 2^k sample pairs per
// frame (k selectable at run time, clamped to MAX_LOG2_DEC). Each frame yields
// a signed 16-bit floor-mean per lane, presented on an AXI-Stream master that
// holds one beat. The ADC side cannot be stalled, so a result that finds the
// output register still occupied is dropped and counted as an overrun.
//
// Ports:
//   aclk                  sole clock, rising edge
//   reset                 asynchronous, active-high reset
//   S_AXIS_SIGNAL_tdata   lane X in [13:0], lane Y in [29:16]
//   S_AXIS_SIGNAL_tvalid  sample qualifier (no tready)
//   cfg_enable            run decimation
//   cfg_log2_dec          requested decimation exponent k
//   M_AXIS_S01_tdata      {Y mean, X mean}
//   M_AXIS_S01_tvalid     result valid
//   M_AXIS_S01_tready     downstream accept
//   dec_strobe            one-cycle pulse when a result loads
//   active_log2_dec       exponent in force for the current frame
//   overrun               sticky flag: a result was dropped
//   overrun_count         saturating count of dropped results

module axis_decimation_controller #(
   parameter int AXIS_SIGNAL_TDATA_WIDTH            = 32,
   parameter int AXIS_SIGNAL_DATA_WIDTH             = 16,
   parameter int AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH = 14,
   parameter int MAX_LOG2_DEC                       = 8
) (
   input  logic                               aclk,
   input  logic                               reset,
   input  logic [AXIS_SIGNAL_TDATA_WIDTH-1:0] S_AXIS_SIGNAL_tdata,
   input  logic                               S_AXIS_SIGNAL_tvalid,
   input  logic                               cfg_enable,
   input  logic [3:0]                         cfg_log2_dec,
   output logic [AXIS_SIGNAL_TDATA_WIDTH-1:0] M_AXIS_S01_tdata,
   output logic                               M_AXIS_S01_tvalid,
   input  logic                               M_AXIS_S01_tready,
   output logic                               dec_strobe,
   output logic [3:0]                         active_log2_dec,
   output logic                               overrun,
   output logic [15:0]                        overrun_count
);

   localparam int SIG_W = AXIS_SIGNAL_SIGNIFICANT_DATA_WIDTH;
   localparam int OUT_W = AXIS_SIGNAL_DATA_WIDTH;
   localparam int ACC_W = SIG_W + MAX_LOG2_DEC;
   localparam int CNT_W = MAX_LOG2_DEC + 1;
   localparam logic [3:0] MAX_K = 4'(MAX_LOG2_DEC);

   typedef enum logic {
      IDLE,
      ACCUM
   } state_t;

   state_t state;
   state_t state_next;

   logic in_accum;
   logic accept;

   logic [3:0]              cfg_clamped;
   logic signed [ACC_W-1:0] acc_x;
   logic signed [ACC_W-1:0] acc_y;
   logic signed [ACC_W-1:0] x_ext;
   logic signed [ACC_W-1:0] y_ext;
   logic signed [ACC_W-1:0] sum_x;
   logic signed [ACC_W-1:0] sum_y;
   logic signed [ACC_W-1:0] mean_x;
   logic signed [ACC_W-1:0] mean_y;
   logic [CNT_W-1:0]        sample_count;
   logic [CNT_W-1:0]        last_count;

   logic frame_last;
   logic frame_done;
   logic out_free;
   logic load;
   logic drop;
   logic unused_bits;

   // Requested exponents beyond what the accumulator can hold are clamped.
   assign cfg_clamped = (cfg_log2_dec > MAX_K) ? MAX_K : cfg_log2_dec;

   // Each lane's 14-bit two's-complement value widened to accumulator width.
   assign x_ext = {{(ACC_W-SIG_W){S_AXIS_SIGNAL_tdata[SIG_W-1]}},
                   S_AXIS_SIGNAL_tdata[SIG_W-1:0]};
   assign y_ext = {{(ACC_W-SIG_W){S_AXIS_SIGNAL_tdata[OUT_W+SIG_W-1]}},
                   S_AXIS_SIGNAL_tdata[OUT_W+SIG_W-1:OUT_W]};

   // The closing sample is folded in combinationally so the mean is ready on
   // the same edge that accepts it. The arithmetic shift floors toward -inf.
   assign sum_x  = acc_x + x_ext;
   assign sum_y  = acc_y + y_ext;
   assign mean_x = sum_x >>> active_log2_dec;
   assign mean_y = sum_y >>> active_log2_dec;

   // The counter holds samples already absorbed, so the frame closes when it
   // reads 2^k - 1 as another sample arrives.
   assign last_count = (CNT_W'(1) << active_log2_dec) - CNT_W'(1);
   assign frame_last = accept && (sample_count == last_count);

   // Dropping enable on the closing edge discards the frame: exit wins.
   assign frame_done = frame_last && cfg_enable;
   assign out_free   = !M_AXIS_S01_tvalid || M_AXIS_S01_tready;
   assign load       = frame_done && out_free;
   assign drop       = frame_done && !out_free;

   assign unused_bits = ^{S_AXIS_SIGNAL_tdata[AXIS_SIGNAL_TDATA_WIDTH-1:OUT_W+SIG_W],
                          S_AXIS_SIGNAL_tdata[OUT_W-1:SIG_W],
                          mean_x[ACC_W-1:OUT_W], mean_y[ACC_W-1:OUT_W]};

   // State register.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: enable alone moves between idling and accumulating.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cfg_enable)  state_next = ACCUM;
         ACCUM:   if (!cfg_enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State-derived controls: samples count only while accumulating.
   always_comb begin
      in_accum = 1'b0;
      accept   = 1'b0;
      if (state == ACCUM) begin
         in_accum = 1'b1;
         accept   = S_AXIS_SIGNAL_tvalid;
      end
   end

   // Accumulators and sample counter. They sit at zero while idle, are wiped
   // when enable falls (partial frame discarded) and restart after each frame.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         acc_x        <= '0;
         acc_y        <= '0;
         sample_count <= '0;
      end else if (!in_accum || !cfg_enable || frame_last) begin
         acc_x        <= '0;
         acc_y        <= '0;
         sample_count <= '0;
      end else if (accept) begin
         acc_x        <= sum_x;
         acc_y        <= sum_y;
         sample_count <= sample_count + CNT_W'(1);
      end
   end

   // The exponent is captured on entering accumulation and again at every
   // frame boundary, so a mid-frame change never splits a frame.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         active_log2_dec <= '0;
      end else if ((state == IDLE && cfg_enable) || frame_done) begin
         active_log2_dec <= cfg_clamped;
      end
   end

   // Overrun bookkeeping. A fresh run starts with a clean record; otherwise
   // each dropped result sets the sticky flag and bumps a saturating count.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         overrun       <= 1'b0;
         overrun_count <= '0;
      end else if (state == IDLE && cfg_enable) begin
         overrun       <= 1'b0;
         overrun_count <= '0;
      end else if (drop) begin
         overrun <= 1'b1;
         if (overrun_count != 16'hFFFF) begin
            overrun_count <= overrun_count + 16'd1;
         end
      end
   end

   // One-deep output register. A new result may load when the register is
   // empty or is being drained this very cycle; a held beat never changes
   // until accepted, and survives a drop back to idle.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         M_AXIS_S01_tdata  <= '0;
         M_AXIS_S01_tvalid <= 1'b0;
         dec_strobe        <= 1'b0;
      end else begin
         dec_strobe <= load;
         if (load) begin
            M_AXIS_S01_tdata  <= {mean_y[OUT_W-1:0], mean_x[OUT_W-1:0]};
            M_AXIS_S01_tvalid <= 1'b1;
         end else if (M_AXIS_S01_tvalid && M_AXIS_S01_tready) begin
            M_AXIS_S01_tvalid <= 1'b0;
         end
      end
   end

endmodule
